// File: rtl/conva3_ofm_store_pkg.sv
// Shared declarations for the OFM store: FSM state encoding, the default
// word width and the address-width helper used by the top and the RAM.
package conva3_ofm_store_pkg;

  // Pass controller states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREFETCH = 2'd1,
    ACTIVE   = 2'd2,
    DONE     = 2'd3
  } ofm_state_t;

  // Float word width used when the instantiator does not override it
  localparam int DEF_DATA_WIDTH = 32;

  // Bits needed to address 'depth' entries (at least one bit)
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ofm_dual_port_memory.sv
// Simple dual-port RAM backing the output feature maps: one write port and
// one registered read port. Contents are never cleared; the read register
// only updates when a read is enabled, so it holds its last value otherwise.
module ofm_dual_port_memory
  import conva3_ofm_store_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = addr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_W-1:0]     i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_W-1:0]     i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Write port
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read port; holds when not enabled
  always_ff @(posedge clk) begin
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/conva3_ofm_store.sv
// Output-feature-map store and partial-sum server for the three-unit
// convolution datapath. During a pass it presents the stored partial sum of
// the current pixel and writes the accumulated result back in place; between
// passes the next layer reads finished maps through a registered read port.
// Optional feature macro: OFM_ZERO_FIRST_EN -- when defined, a pass started
// with first_pass = 1 serves zero partial sums and skips memory reads.
module conva3_ofm_store
  import conva3_ofm_store_pkg::*;
#(
  parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
  parameter int IFM_SIZE_NEXT     = 28,
  parameter int NUMBER_OF_FILTERS = 120,
  parameter int PIXELS            = IFM_SIZE_NEXT * IFM_SIZE_NEXT,
  parameter int ADDRESS_SIZE_OFM  = addr_width(PIXELS * NUMBER_OF_FILTERS),
  parameter int FILTER_INDEX_W    = addr_width(NUMBER_OF_FILTERS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [FILTER_INDEX_W-1:0]   filter_index,
  input  logic                        first_pass,
  input  logic                        data_valid,
  input  logic [DATA_WIDTH-1:0]       data_in,
  output logic [DATA_WIDTH-1:0]       partial_sum_out,
  output logic                        ready,
  output logic                        busy,
  output logic                        done,
  input  logic                        rd_enable,
  input  logic [ADDRESS_SIZE_OFM-1:0] rd_address,
  output logic [DATA_WIDTH-1:0]       rd_data
);

  localparam int PIX_W = addr_width(PIXELS);
  localparam int DEPTH = PIXELS * NUMBER_OF_FILTERS;
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(PIXELS - 1);

  ofm_state_t r_state;
  ofm_state_t w_state_next;

  logic                        w_accept_start;
  logic                        w_pix_write;
  logic                        w_last_pix;
  logic [PIX_W-1:0]            r_pix;
  logic [ADDRESS_SIZE_OFM-1:0] r_base;
  logic [ADDRESS_SIZE_OFM-1:0] w_start_base;
  logic [ADDRESS_SIZE_OFM-1:0] w_pix_addr;

  logic                        w_mem_wr_en;
  logic                        w_mem_rd_en;
  logic [ADDRESS_SIZE_OFM-1:0] w_mem_rd_addr;
  logic [DATA_WIDTH-1:0]       w_mem_rd_data;

  // Zero-partial-sum controls: at the start edge (input not yet latched)
  // and for the remainder of the pass.
  logic                        w_zero_start;
  logic                        w_zero_pass;

  // External read data path: r_ext_sel means the RAM read register still
  // holds the last external read; otherwise r_rd_hold keeps it stable while
  // a pass reuses the read port.
  logic                        r_ext_sel;
  logic [DATA_WIDTH-1:0]       r_rd_hold;
  logic [DATA_WIDTH-1:0]       w_rd_data;

  assign w_start_base = ADDRESS_SIZE_OFM'(filter_index) * ADDRESS_SIZE_OFM'(PIXELS);
  assign w_pix_addr   = r_base + ADDRESS_SIZE_OFM'(r_pix);
  assign w_last_pix   = (r_pix == LAST_PIX);

`ifdef OFM_ZERO_FIRST_EN
  logic r_first;

  // Remember whether this pass is the first depth group of the map
  always_ff @(posedge clk) begin
    if (reset) begin
      r_first <= 1'b0;
    end else if (w_accept_start) begin
      r_first <= first_pass;
    end
  end

  assign w_zero_start = first_pass;
  assign w_zero_pass  = r_first;
`else
  logic w_unused_first;

  assign w_unused_first = first_pass;
  assign w_zero_start   = 1'b0;
  assign w_zero_pass    = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state and per-cycle strobes
  always_comb begin
    w_state_next   = r_state;
    w_accept_start = 1'b0;
    w_pix_write    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next   = PREFETCH;
          w_accept_start = 1'b1;
        end
      end
      PREFETCH: begin
        w_state_next = ACTIVE;
      end
      ACTIVE: begin
        if (data_valid) begin
          w_pix_write = 1'b1;
          if (w_last_pix) begin
            w_state_next = DONE;
          end
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Pass base, pixel counter and external-read bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_base    <= '0;
      r_pix     <= '0;
      r_ext_sel <= 1'b0;
      r_rd_hold <= '0;
    end else begin
      if (w_accept_start) begin
        r_base    <= w_start_base;
        r_pix     <= '0;
        r_ext_sel <= 1'b0;
        r_rd_hold <= w_rd_data;
      end else if ((r_state == IDLE) && rd_enable) begin
        r_ext_sel <= 1'b1;
      end
      if (w_pix_write && !w_last_pix) begin
        r_pix <= r_pix + PIX_W'(1);
      end
    end
  end

  // Read-port arbitration: a starting pass fetches its first pixel, an
  // accepted write prefetches the next pixel, and only an idle store serves
  // external reads. Reset blocks every access so an aborted pass stops cold.
  always_comb begin
    w_mem_rd_en   = 1'b0;
    w_mem_rd_addr = rd_address;
    if (!reset) begin
      if (w_accept_start) begin
        w_mem_rd_addr = w_start_base;
        w_mem_rd_en   = !w_zero_start;
      end else if (w_pix_write && !w_last_pix) begin
        w_mem_rd_addr = w_pix_addr + ADDRESS_SIZE_OFM'(1);
        w_mem_rd_en   = !w_zero_pass;
      end else if ((r_state == IDLE) && rd_enable) begin
        w_mem_rd_en   = 1'b1;
      end
    end
  end

  assign w_mem_wr_en = w_pix_write && !reset;

  ofm_dual_port_memory #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDRESS_SIZE_OFM)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_mem_wr_en),
    .i_wr_addr (w_pix_addr),
    .i_wr_data (data_in),
    .i_rd_en   (w_mem_rd_en),
    .i_rd_addr (w_mem_rd_addr),
    .o_rd_data (w_mem_rd_data)
  );

  assign ready           = (r_state == ACTIVE);
  assign busy            = (r_state != IDLE);
  assign done            = (r_state == DONE);
  assign partial_sum_out = (ready && !w_zero_pass) ? w_mem_rd_data : '0;
  assign w_rd_data       = r_ext_sel ? w_mem_rd_data : r_rd_hold;
  assign rd_data         = w_rd_data;

endmodule
